// File: rtl/daq_frame_gen.sv
// DAQ frame generator: header, interleaved-channel payload lines, tailer, inter-frame gap.
// Define DAQ_FRAME_CHKSUM_EN to insert an XOR checksum word between payload and tailer.
module daq_frame_gen #(
  parameter int N_CH            = 4,
  parameter int WORDS_PER_LINE  = 24,
  parameter int LINES_PER_FRAME = 16,
  parameter int GAP_CYCLES      = 8
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        cfg_wren,
  input  logic [7:0]  cfg_data,
  input  logic        stream_open,
  input  logic        fifo_full,
  output logic [31:0] data_out,
  output logic        data_wren,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [7:0]  CMD_START  = 8'hFF;
  localparam logic [7:0]  CMD_RESET  = 8'hC0;
  localparam logic [7:0]  CMD_CLOSE  = 8'hC7;
  localparam logic [7:0]  CH_LAST    = 8'(N_CH - 1);
  localparam logic [15:0] WORD_LAST  = 16'(WORDS_PER_LINE - 1);
  localparam logic [7:0]  LINE_LAST  = 8'(LINES_PER_FRAME - 1);
  localparam logic [7:0]  LINE_TOTAL = 8'(LINES_PER_FRAME % 256);
  localparam logic [15:0] GAP_LAST   = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
`ifdef DAQ_FRAME_CHKSUM_EN
    S_CHKSUM,
`endif
    S_TAILER,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  line_q, line_d;
  logic [7:0]  ch_q, ch_d;
  logic [23:0] pcnt_q, pcnt_d;
  logic [15:0] gap_q, gap_d;
  logic [15:0] frame_q, frame_d;
  logic        close_q, close_d;
`ifdef DAQ_FRAME_CHKSUM_EN
  logic [31:0] chk_q, chk_d;
`endif
  logic        rst_sync_q;
  logic        core_rst_n;
  logic        cmd_start, cmd_reset, cmd_close, abort, emit;

  // Single release flop: the core leaves reset on the first edge, so it takes a command on the second.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) rst_sync_q <= 1'b0;
    else            rst_sync_q <= 1'b1;
  end
  assign core_rst_n = rst_sync_q;

  assign cmd_start = cfg_wren && (cfg_data == CMD_START);
  assign cmd_reset = cfg_wren && (cfg_data == CMD_RESET);
  assign cmd_close = cfg_wren && (cfg_data == CMD_CLOSE);
  assign abort     = !stream_open || cmd_reset;

  always_comb begin
    emit = 1'b0;
    data_out = 32'h0;
    case (state_q)
      S_HEADER:  begin emit = 1'b1; data_out = {8'hF0, 8'h00, frame_q}; end
      S_PAYLOAD: begin emit = 1'b1; data_out = {ch_q, pcnt_q}; end
`ifdef DAQ_FRAME_CHKSUM_EN
      S_CHKSUM:  begin emit = 1'b1; data_out = chk_q; end
`endif
      S_TAILER:  begin emit = 1'b1; data_out = {8'hAA, LINE_TOTAL, frame_q}; end
      default:   begin emit = 1'b0; data_out = 32'h0; end
    endcase
  end

  assign data_wren = emit && !fifo_full && !abort;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_q;

  // Everything except abort handling advances only on an accepted word.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    line_d  = line_q;
    ch_d    = ch_q;
    pcnt_d  = pcnt_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    close_d = close_q;
`ifdef DAQ_FRAME_CHKSUM_EN
    chk_d   = chk_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
      word_d  = 16'h0;
      line_d  = 8'h0;
      ch_d    = 8'h0;
      pcnt_d  = 24'h0;
      gap_d   = 16'h0;
      frame_d = 16'h0;
      close_d = 1'b0;
`ifdef DAQ_FRAME_CHKSUM_EN
      chk_d   = 32'h0;
`endif
    end else begin
      if (cmd_close) close_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          close_d = 1'b0;
          if (cmd_start) state_d = S_HEADER;
        end
        S_HEADER: begin
          if (data_wren) begin
            state_d = S_PAYLOAD;
            word_d  = 16'h0;
            line_d  = 8'h0;
            ch_d    = 8'h0;
`ifdef DAQ_FRAME_CHKSUM_EN
            chk_d   = 32'h0;
`endif
          end
        end
        S_PAYLOAD: begin
          if (data_wren) begin
            pcnt_d = pcnt_q + 24'd1;
`ifdef DAQ_FRAME_CHKSUM_EN
            chk_d  = chk_q ^ data_out;
`endif
            if (word_q == WORD_LAST) begin
              word_d = 16'h0;
              ch_d   = 8'h0;
              if (line_q == LINE_LAST) begin
                line_d = 8'h0;
`ifdef DAQ_FRAME_CHKSUM_EN
                state_d = S_CHKSUM;
`else
                state_d = S_TAILER;
`endif
              end else begin
                line_d = line_q + 8'd1;
              end
            end else begin
              word_d = word_q + 16'd1;
              ch_d   = (ch_q == CH_LAST) ? 8'h0 : ch_q + 8'd1;
            end
          end
        end
`ifdef DAQ_FRAME_CHKSUM_EN
        S_CHKSUM: begin
          if (data_wren) state_d = S_TAILER;
        end
`endif
        S_TAILER: begin
          if (data_wren) begin
            frame_d = frame_q + 16'd1;
            gap_d   = 16'h0;
            if (close_q || cmd_close) begin
              state_d = S_IDLE;
              close_d = 1'b0;
            end else if (GAP_CYCLES == 0) begin
              state_d = S_HEADER;
            end else begin
              state_d = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cmd_close) begin
            state_d = S_IDLE;
            close_d = 1'b0;
          end else if (gap_q == GAP_LAST) begin
            state_d = S_HEADER;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= S_IDLE;
      word_q  <= 16'h0;
      line_q  <= 8'h0;
      ch_q    <= 8'h0;
      pcnt_q  <= 24'h0;
      gap_q   <= 16'h0;
      frame_q <= 16'h0;
      close_q <= 1'b0;
`ifdef DAQ_FRAME_CHKSUM_EN
      chk_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      line_q  <= line_d;
      ch_q    <= ch_d;
      pcnt_q  <= pcnt_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      close_q <= close_d;
`ifdef DAQ_FRAME_CHKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_daq_frame_gen.sv
// Directed bench for daq_frame_gen with default parameters; expects the checksum
// word when DAQ_FRAME_CHKSUM_EN is defined.
module tb_daq_frame_gen;

  localparam int W     = 24;
  localparam int NCH   = 4;
  localparam int TOTAL = 384;
  localparam int GAP   = 8;

  logic        bus_clk = 1'b0;
  logic        bus_rst_n = 1'b0;
  logic        cfg_wren = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        stream_open = 1'b1;
  logic        fifo_full = 1'b0;
  logic [31:0] data_out;
  logic        data_wren;
  logic        busy;
  logic [15:0] frame_cnt;

  int          nChecks = 0;
  int          nFails = 0;
  logic [23:0] expPcnt = 24'h0;

  daq_frame_gen dut (
    .bus_clk     (bus_clk),
    .bus_rst_n   (bus_rst_n),
    .cfg_wren    (cfg_wren),
    .cfg_data    (cfg_data),
    .stream_open (stream_open),
    .fifo_full   (fifo_full),
    .data_out    (data_out),
    .data_wren   (data_wren),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  function automatic logic [31:0] payloadWord(input int idx, input logic [23:0] p);
    logic [7:0] ch;
    ch = 8'((idx % W) % NCH);
    return {ch, p};
  endfunction

  task automatic tick_sample();
    @(negedge bus_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    @(negedge bus_clk);
    cfg_wren = 1'b1;
    cfg_data = c;
    @(posedge bus_clk);
    #1;
    cfg_wren = 1'b0;
    cfg_data = 8'h00;
  endtask

  // Waits (bounded) for the next cycle with data_wren high and returns the word shown.
  task automatic next_word(input int budget, output logic [31:0] w, output bit ok, output int waited);
    ok = 1'b0;
    w = 32'h0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge bus_clk);
      #1;
      waited++;
      if (data_wren === 1'b1) begin
        w = data_out;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge bus_clk);
    #1;
    nChecks++;
    if (data_wren !== 1'b0) begin nFails++; $display("[TB] FAIL reset_wren got %b want 0", data_wren); end
    nChecks++;
    if (data_out !== 32'h0) begin nFails++; $display("[TB] FAIL reset_data got %h want 00000000", data_out); end
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    nChecks++;
    if (frame_cnt !== 16'h0) begin nFails++; $display("[TB] FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
    @(negedge bus_clk);
    bus_rst_n = 1'b1;
    repeat (2) @(negedge bus_clk);
  endtask

  task automatic test_full_frame();
    logic [31:0] w, exp, chk;
    bit ok;
    int waited;
    chk = 32'h0;
    send_cmd(8'hFF);
    next_word(5, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hF0000000) begin nFails++; $display("[TB] FAIL full_header got %h want F0000000", w); end
    for (int i = 0; i < TOTAL; i++) begin
      exp = payloadWord(i, expPcnt);
      next_word(3, w, ok, waited);
      nChecks++;
      if (!ok || w !== exp) begin nFails++; $display("[TB] FAIL full_payload[%0d] got %h want %h", i, w, exp); end
      chk = chk ^ exp;
      expPcnt = expPcnt + 24'd1;
    end
`ifdef DAQ_FRAME_CHKSUM_EN
    next_word(3, w, ok, waited);
    nChecks++;
    if (!ok || w !== chk) begin nFails++; $display("[TB] FAIL full_chksum got %h want %h", w, chk); end
`endif
    next_word(3, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hAA100000) begin nFails++; $display("[TB] FAIL full_tailer got %h want AA100000", w); end
    next_word(30, w, ok, waited);
    nChecks++;
    if (!ok || waited != GAP + 1) begin nFails++; $display("[TB] FAIL gap_length got %0d want %0d", waited, GAP + 1); end
    nChecks++;
    if (w !== 32'hF0000001) begin nFails++; $display("[TB] FAIL next_header got %h want F0000001", w); end
    nChecks++;
    if (frame_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL full_frame_cnt got %0d want 1", frame_cnt); end
    send_cmd(8'hC0);
    expPcnt = 24'h0;
    tick_sample();
    nChecks++;
    if (busy !== 1'b0 || frame_cnt !== 16'h0) begin
      nFails++; $display("[TB] FAIL full_reset got busy=%b cnt=%0d want busy=0 cnt=0", busy, frame_cnt);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] w, exp;
    bit ok;
    int waited;
    send_cmd(8'hFF);
    next_word(5, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hF0000000) begin nFails++; $display("[TB] FAIL ff_header got %h want F0000000", w); end
    for (int i = 0; i < 30; i++) begin
      exp = payloadWord(i, expPcnt);
      if (i == 5) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge bus_clk);
          fifo_full = 1'b1;
          #1;
          nChecks++;
          if (data_wren !== 1'b0 || data_out !== exp) begin
            nFails++; $display("[TB] FAIL ff_stall[%0d] got wren=%b data=%h want wren=0 data=%h", s, data_wren, data_out, exp);
          end
        end
        @(negedge bus_clk);
        fifo_full = 1'b0;
        #1;
        w = data_out;
        ok = (data_wren === 1'b1);
      end else begin
        next_word(3, w, ok, waited);
      end
      nChecks++;
      if (!ok || w !== exp) begin nFails++; $display("[TB] FAIL ff_payload[%0d] got %h want %h", i, w, exp); end
      expPcnt = expPcnt + 24'd1;
    end
    send_cmd(8'hC0);
    expPcnt = 24'h0;
  endtask

  task automatic test_close();
    logic [31:0] w, exp, chk;
    bit ok, seen;
    int waited;
    chk = 32'h0;
    send_cmd(8'hFF);
    next_word(5, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hF0000000) begin nFails++; $display("[TB] FAIL close_header got %h want F0000000", w); end
    for (int i = 0; i < TOTAL; i++) begin
      exp = payloadWord(i, expPcnt);
      if (i == 10) begin
        @(negedge bus_clk);
        cfg_wren = 1'b1;
        cfg_data = 8'hC7;
        #1;
        w = data_out;
        ok = (data_wren === 1'b1);
        @(posedge bus_clk);
        #1;
        cfg_wren = 1'b0;
        cfg_data = 8'h00;
      end else begin
        next_word(3, w, ok, waited);
      end
      nChecks++;
      if (!ok || w !== exp) begin nFails++; $display("[TB] FAIL close_payload[%0d] got %h want %h", i, w, exp); end
      chk = chk ^ exp;
      expPcnt = expPcnt + 24'd1;
    end
`ifdef DAQ_FRAME_CHKSUM_EN
    next_word(3, w, ok, waited);
    nChecks++;
    if (!ok || w !== chk) begin nFails++; $display("[TB] FAIL close_chksum got %h want %h", w, chk); end
`endif
    next_word(3, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hAA100000) begin nFails++; $display("[TB] FAIL close_tailer got %h want AA100000", w); end
    tick_sample();
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL close_busy got %b want 0", busy); end
    nChecks++;
    if (frame_cnt !== 16'd1) begin nFails++; $display("[TB] FAIL close_frame_cnt got %0d want 1", frame_cnt); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_sample();
      if (data_wren !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    nChecks++;
    if (seen) begin nFails++; $display("[TB] FAIL close_no_restart got activity want none"); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, exp;
    bit ok;
    int waited;
    send_cmd(8'hFF);
    next_word(5, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hF0000001) begin nFails++; $display("[TB] FAIL rst_header got %h want F0000001", w); end
    for (int i = 0; i < 10; i++) begin
      exp = payloadWord(i, expPcnt);
      next_word(3, w, ok, waited);
      nChecks++;
      if (!ok || w !== exp) begin nFails++; $display("[TB] FAIL rst_payload[%0d] got %h want %h", i, w, exp); end
      expPcnt = expPcnt + 24'd1;
    end
    @(negedge bus_clk);
    cfg_wren = 1'b1;
    cfg_data = 8'hC0;
    #1;
    nChecks++;
    if (data_wren !== 1'b0) begin nFails++; $display("[TB] FAIL rst_wren_same_cycle got %b want 0", data_wren); end
    @(posedge bus_clk);
    #1;
    cfg_wren = 1'b0;
    cfg_data = 8'h00;
    expPcnt = 24'h0;
    tick_sample();
    nChecks++;
    if (busy !== 1'b0 || frame_cnt !== 16'h0) begin
      nFails++; $display("[TB] FAIL rst_idle got busy=%b cnt=%0d want busy=0 cnt=0", busy, frame_cnt);
    end
    send_cmd(8'hFF);
    next_word(5, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hF0000000) begin nFails++; $display("[TB] FAIL rst_new_header got %h want F0000000", w); end
    next_word(3, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'h00000000) begin nFails++; $display("[TB] FAIL rst_new_payload got %h want 00000000", w); end
    send_cmd(8'hC0);
    expPcnt = 24'h0;
  endtask

  task automatic test_stream_open();
    logic [31:0] w, exp;
    bit ok;
    int waited;
    send_cmd(8'hFF);
    next_word(5, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hF0000000) begin nFails++; $display("[TB] FAIL so_header got %h want F0000000", w); end
    for (int i = 0; i < 5; i++) begin
      exp = payloadWord(i, expPcnt);
      next_word(3, w, ok, waited);
      nChecks++;
      if (!ok || w !== exp) begin nFails++; $display("[TB] FAIL so_payload[%0d] got %h want %h", i, w, exp); end
      expPcnt = expPcnt + 24'd1;
    end
    @(negedge bus_clk);
    stream_open = 1'b0;
    #1;
    nChecks++;
    if (data_wren !== 1'b0) begin nFails++; $display("[TB] FAIL so_drop_wren got %b want 0", data_wren); end
    send_cmd(8'hFF);
    tick_sample();
    nChecks++;
    if (busy !== 1'b0 || data_wren !== 1'b0) begin
      nFails++; $display("[TB] FAIL so_start_ignored got busy=%b wren=%b want 0 0", busy, data_wren);
    end
    @(negedge bus_clk);
    stream_open = 1'b1;
    repeat (3) tick_sample();
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL so_reopen_idle got busy=%b want 0", busy); end
    expPcnt = 24'h0;
    send_cmd(8'hFF);
    next_word(5, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'hF0000000) begin nFails++; $display("[TB] FAIL so_new_header got %h want F0000000", w); end
    next_word(3, w, ok, waited);
    nChecks++;
    if (!ok || w !== 32'h00000000) begin nFails++; $display("[TB] FAIL so_new_payload got %h want 00000000", w); end
    send_cmd(8'hC0);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_fifo_full();
    test_close();
    test_reset_mid();
    test_stream_open();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/daq_frame_gen.md
DAQ_FRAME_GEN -- requirements
Module: daq_frame_gen

Interface
REQ-001 Parameter N_CH, default 4, number of channel IDs interleaved per line (1..256).
REQ-002 Parameter WORDS_PER_LINE, default 24, payload words per line (1..65535).
REQ-003 Parameter LINES_PER_FRAME, default 16, lines per frame (1..256).
REQ-004 Parameter GAP_CYCLES, default 8, idle cycles between frames (0..65535).
REQ-005 bus_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 bus_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cfg_wren  in  1  one-cycle strobe; cfg_data is a command byte.
REQ-008 cfg_data  in  8  command byte: 0xFF START, 0xC0 RESET, 0xC7 CLOSE; others ignored.
REQ-009 stream_open  in  1  host read stream open; low aborts generation.
REQ-010 fifo_full  in  1  downstream FIFO full.
REQ-011 data_out  out  32  frame word presented to the FIFO.
REQ-012 data_wren  out  1  write strobe; one word accepted per cycle high.
REQ-013 busy  out  1  high in any state other than IDLE; drives the data LED.
REQ-014 frame_cnt  out  16  count of completed frames (tailer accepted).

Function
REQ-015 FSM states: IDLE, HEADER, PAYLOAD, (CHKSUM), TAILER, GAP.
REQ-016 Emit states are HEADER, PAYLOAD, CHKSUM and TAILER; data_wren = emit state AND !fifo_full, combinational; data_out is held stable while fifo_full is high.
REQ-017 The FSM advances, and the word/line/channel counters update, only on cycles where data_wren=1.
REQ-018 Header word = {8'hF0, 8'h00, frame_cnt[15:0]}.
REQ-019 Payload word = {ch[7:0], pcnt[23:0]}; ch increments per word, wrapping N_CH-1 to 0, and resets to 0 at each line start; pcnt is a 24-bit free-running counter that wraps 0xFFFFFF to 0 and persists across frames.
REQ-020 PAYLOAD emits WORDS_PER_LINE*LINES_PER_FRAME words, then goes to CHKSUM if compiled in, else TAILER.
REQ-021 Tailer word = {8'hAA, line_total[7:0], frame_cnt[15:0]}, where line_total = LINES_PER_FRAME mod 256; frame_cnt increments (wrapping 16 bits) when the tailer is accepted.
REQ-022 After the tailer: GAP for GAP_CYCLES cycles, then HEADER; if GAP_CYCLES=0, go directly to HEADER.
REQ-023 START in IDLE: HEADER on the next cycle. START in any other state: ignored.
REQ-024 CLOSE: set close_pending; the current frame completes through the tailer, then the FSM goes to IDLE instead of GAP. CLOSE in IDLE or GAP: IDLE next cycle.
REQ-025 RESET in any state: IDLE next cycle; clear pcnt, frame_cnt and close_pending; data_wren goes low the same cycle as the strobe.
REQ-026 stream_open low in any state: same effect as RESET, held for as long as stream_open is low; START is ignored while stream_open is low.
REQ-027 Priority on a simultaneous cycle: stream_open low > RESET > CLOSE > START.
REQ-028 A partial frame is never resumed; after an abort, the next START begins a new header.

Reset
REQ-029 While bus_rst_n=0: state IDLE, data_wren=0, data_out=0, busy=0, frame_cnt=0, pcnt=0, all counters and close_pending=0.
REQ-030 Reset deassertion is synchronised internally to bus_clk; the first command is accepted on the second edge after release.

Configuration
REQ-031 Macro DAQ_FRAME_CHKSUM_EN defined: CHKSUM state is present and emits one word equal to the XOR of all payload words of the frame, inserted between the last payload word and the tailer.
REQ-032 Macro DAQ_FRAME_CHKSUM_EN undefined: there is no CHKSUM state or logic, and a frame is header + payload + tailer.

Verification
REQ-033 Defaults, fifo_full=0, START -> header 0xF0000000, then 384 payload words 0x00000000, 0x01000001, 0x02000002, 0x03000003, 0x00000004 ..., then tailer 0xAA100000, 8 idle cycles, then header 0xF0000001.
REQ-034 fifo_full high for 5 cycles mid-payload -> data_wren=0 and data_out frozen for those cycles; no word is lost or duplicated and pcnt stays contiguous.
REQ-035 CLOSE at payload word 10 -> frame completes, tailer is accepted, frame_cnt=1, busy falls the next cycle, and no new header follows.
REQ-036 RESET at payload word 10 -> data_wren low the same cycle, IDLE next cycle; a following START yields header 0xF0000000 and first payload 0x00000000.
REQ-037 stream_open dropped mid-frame, with START issued while it is low -> no output; after stream_open rises and a new START, the frame begins at header 0xF0000000.
REQ-038 DAQ_FRAME_CHKSUM_EN with N_CH=1, WORDS_PER_LINE=2, LINES_PER_FRAME=1 -> sequence 0xF0000000, 0x00000000, 0x00000001, 0x00000001, 0xAA010000.
